// File: rtl/datetime_load_sequencer.sv
// Validates a host BCD date/time word and writes it into the century clock counters,
// one field per cycle, highest field first. Optional readback check: `define LOAD_VERIFY_EN.
module datetime_load_sequencer #(
   parameter logic [7:0] CC_MIN = 8'h20,
   parameter logic [7:0] CC_MAX = 8'h30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       allow,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_sec,
   input  logic [7:0] req_min,
   input  logic [7:0] req_hr,
   input  logic [7:0] req_day,
   input  logic [7:0] req_mon,
   input  logic [7:0] req_yy,
   input  logic [7:0] req_cc,
`ifdef LOAD_VERIFY_EN
   input  logic [7:0] rb_sec,
   input  logic [7:0] rb_min,
   input  logic [7:0] rb_hr,
   input  logic [7:0] rb_day,
   input  logic [7:0] rb_mon,
   input  logic [7:0] rb_yy,
   input  logic [7:0] rb_cc,
`endif
   output logic       hold_run,
   output logic       tick_restart,
   output logic [6:0] load_en,
   output logic [7:0] load_val,
   output logic       done,
   output logic       err,
   output logic [2:0] err_code,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_LOAD   = 3'd2,
`ifdef LOAD_VERIFY_EN
      S_VERIFY = 3'd3,
`endif
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] fidx_q, fidx_d;
   logic [2:0] idx_m1;
   logic [7:0] sel_val;
   logic [7:0] fld_q [0:6];
   logic       accept;

   logic       hold_d, tick_d, done_d, err_d;
   logic [6:0] load_en_d;
   logic [7:0] load_val_d;
   logic [2:0] err_code_d;

   logic [6:0] bad;
   logic [2:0] bad_idx;
   logic       leap, yy_div4, mon_ok;
   logic [7:0] dim;

   // Handshake: a request is taken on a rising edge where req_valid && req_ready;
   // req_ready is allow qualified by IDLE, and the fields are captured at that edge.
   assign req_ready = allow && (state_q == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign state_dbg = state_q;
   assign idx_m1    = fidx_q - 3'd1;

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Fields index 0..6 = sec, min, hr, day, mon, yy, cc (same order as load_en).
   always_ff @(posedge clk) begin
      if (accept) begin
         fld_q[0] <= req_sec;
         fld_q[1] <= req_min;
         fld_q[2] <= req_hr;
         fld_q[3] <= req_day;
         fld_q[4] <= req_mon;
         fld_q[5] <= req_yy;
         fld_q[6] <= req_cc;
      end
   end

   // Field validation on the captured word.
   always_comb begin
      if (fld_q[5][4])
         yy_div4 = (fld_q[5][3:0] == 4'd2) || (fld_q[5][3:0] == 4'd6);
      else
         yy_div4 = (fld_q[5][3:0] == 4'd0) || (fld_q[5][3:0] == 4'd4) ||
                   (fld_q[5][3:0] == 4'd8);
      if (fld_q[5] != 8'h00)
         leap = yy_div4;
      else
         leap = (fld_q[6] == 8'h20) || (fld_q[6] == 8'h24) || (fld_q[6] == 8'h28);

      case (fld_q[4])
         8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
         8'h02:                      dim = leap ? 8'h29 : 8'h28;
         default:                    dim = 8'h31;
      endcase

      mon_ok = bcd_ok(fld_q[4]) && (fld_q[4] >= 8'h01) && (fld_q[4] <= 8'h12);

      bad[0] = !bcd_ok(fld_q[0]) || (fld_q[0] > 8'h59);
      bad[1] = !bcd_ok(fld_q[1]) || (fld_q[1] > 8'h59);
      bad[2] = !bcd_ok(fld_q[2]) || (fld_q[2] > 8'h23);
      // A bad month makes the day limit meaningless, so the month takes the blame.
      bad[3] = mon_ok && (!bcd_ok(fld_q[3]) || (fld_q[3] == 8'h00) || (fld_q[3] > dim));
      bad[4] = !mon_ok;
      bad[5] = !bcd_ok(fld_q[5]) || ((fld_q[6] == CC_MAX) && (fld_q[5] != 8'h00));
      bad[6] = !bcd_ok(fld_q[6]) || (fld_q[6] < CC_MIN) || (fld_q[6] > CC_MAX);

      bad_idx = 3'd0;
      for (int i = 6; i >= 0; i--) begin
         if (bad[i]) bad_idx = 3'(i);
      end
   end

   always_comb begin
      case (idx_m1)
         3'd0:    sel_val = fld_q[0];
         3'd1:    sel_val = fld_q[1];
         3'd2:    sel_val = fld_q[2];
         3'd3:    sel_val = fld_q[3];
         3'd4:    sel_val = fld_q[4];
         3'd5:    sel_val = fld_q[5];
         3'd6:    sel_val = fld_q[6];
         default: sel_val = 8'h00;
      endcase
   end

`ifdef LOAD_VERIFY_EN
   logic rb_match;
   assign rb_match = (rb_sec == fld_q[0]) && (rb_min == fld_q[1]) && (rb_hr == fld_q[2]) &&
                     (rb_day == fld_q[3]) && (rb_mon == fld_q[4]) && (rb_yy == fld_q[5]) &&
                     (rb_cc == fld_q[6]);
`endif

   // Outputs are computed for the next state so they register alongside it.
   always_comb begin
      state_d    = state_q;
      fidx_d     = fidx_q;
      load_en_d  = 7'd0;
      load_val_d = 8'h00;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_CHECK;
               err_code_d = 3'd0;
            end
         end
         S_CHECK: begin
            if (|bad) begin
               state_d    = S_ERR;
               err_d      = 1'b1;
               err_code_d = bad_idx;
            end else begin
               state_d    = S_LOAD;
               fidx_d     = 3'd6;
               load_en_d  = 7'b100_0000;
               load_val_d = fld_q[6];
            end
         end
         S_LOAD: begin
            if (fidx_q == 3'd0) begin
`ifdef LOAD_VERIFY_EN
               state_d = S_VERIFY;
`else
               state_d = S_DONE;
               done_d  = 1'b1;
`endif
            end else begin
               fidx_d     = idx_m1;
               load_en_d  = 7'd1 << idx_m1;
               load_val_d = sel_val;
               tick_d     = (idx_m1 == 3'd0);
            end
         end
`ifdef LOAD_VERIFY_EN
         S_VERIFY: begin
            if (rb_match) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d    = S_ERR;
               err_d      = 1'b1;
               err_code_d = 3'd7;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      hold_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         fidx_q       <= 3'd0;
         hold_run     <= 1'b0;
         tick_restart <= 1'b0;
         load_en      <= 7'd0;
         load_val     <= 8'h00;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= 3'd0;
      end else begin
         state_q      <= state_d;
         fidx_q       <= fidx_d;
         hold_run     <= hold_d;
         tick_restart <= tick_d;
         load_en      <= load_en_d;
         load_val     <= load_val_d;
         done         <= done_d;
         err          <= err_d;
         err_code     <= err_code_d;
      end
   end

endmodule
